// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and
// default parameter values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
// The clear input is synchronous and wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: resolves memory stalls, taken
// branches, load-use and jumps into write enables and flushes.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs2_i,
  input  logic             id_jump_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             exmem_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_bubble_o,
  output logic [1:0]       state_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              halted;
  logic              mem_stall;
  logic              load_use;
  logic              stall_inc;

  assign halted    = (state == ST_HALT);
  assign mem_stall = !halted && mem_req_i && !mem_ack_i;
  assign load_use  = ex_memread_i && (ex_rd_i != 5'd0) &&
                     ((ex_rd_i == id_rs1_i) || (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
  assign wait_nxt  = wait_cnt + WAIT_W'(1);

  assign state_o = state;
  assign halt_o  = halted;

  // Priority chain: HALT > mem_stall > branch > load_use > jump.
  // A jump under load_use is deliberately not flushed; it stays in ID.
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    idex_write_o   = 1'b1;
    exmem_write_o  = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    if (halted || mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
    end else if (id_jump_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // Wait counter holds the number of stalled cycles; it is 1 on MEM_WAIT entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (mem_stall) begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_W'(MEM_TIMEOUT)) state <= ST_HALT;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // A load_use under a taken branch is on the wrong path and is not counted.
  assign stall_inc = mem_stall || (!halted && load_use && !ex_branch_taken_i);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clear (rst_i),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clear (rst_i),
    .inc   (ifid_flush_o),
    .count (flush_cnt_o)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive data-memory wait cycles before the block halts the pipeline.
REQ-003 SHALL have port clk_i  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1: synchronous, active-high reset.
REQ-005 SHALL have port id_rs1_i  in  5: ID-stage rs1 address (IF/ID instr[19:15]).
REQ-006 SHALL have port id_rs2_i  in  5: ID-stage rs2 address (IF/ID instr[24:20]).
REQ-007 SHALL have port id_use_rs2_i  in  1: the ID instruction reads rs2.
REQ-008 SHALL have port id_jump_i  in  1: the ID instruction is a jump (decoder Jump).
REQ-009 SHALL have port ex_memread_i  in  1: the ID/EX MemRead control bit.
REQ-010 SHALL have port ex_rd_i  in  5: the ID/EX destination register.
REQ-011 SHALL have port ex_branch_taken_i  in  1: a branch in EX resolved taken.
REQ-012 SHALL have port mem_req_i  in  1: EX/MEM holds a load or store.
REQ-013 SHALL have port mem_ack_i  in  1: the data memory completes the access this cycle.
REQ-014 SHALL have enable outputs pc_write_o, ifid_write_o, idex_write_o, exmem_write_o  out  1 each: PC and pipeline-register write enables.
REQ-015 SHALL have flush outputs ifid_flush_o, idex_flush_o, memwb_bubble_o  out  1 each: load a NOP or zero the control bits of that register.
REQ-016 SHALL have port state_o  out  2: FSM state, RUN=0, MEM_WAIT=1, HALT=2.
REQ-017 SHALL have port halt_o  out  1: high while state is HALT.
REQ-018 SHALL have counter outputs stall_cnt_o, flush_cnt_o  out  CNT_W each: event counters.

Function
REQ-019 SHALL define mem_stall = mem_req_i & ~mem_ack_i, evaluated in RUN and MEM_WAIT.
REQ-020 SHALL define load_use = ex_memread_i & (ex_rd_i!=0) & ((ex_rd_i==id_rs1_i) | (id_use_rs2_i & (ex_rd_i==id_rs2_i))).
REQ-021 SHALL resolve events in fixed priority: HALT > mem_stall > ex_branch_taken_i > load_use > id_jump_i.
REQ-022 With no event active, SHALL drive all write enables 1 and all flush/bubble outputs 0.
REQ-023 mem_stall response, combinational in the same cycle: pc/ifid/idex/exmem write enables 0, memwb_bubble_o=1, all other flushes 0.
REQ-024 Branch response: pc_write_o=1, ifid_flush_o=1, idex_flush_o=1; a simultaneous load_use or jump is discarded because it is on the wrong path.
REQ-025 Load-use response: pc_write_o=0, ifid_write_o=0, idex_flush_o=1 (one bubble); the stall lasts exactly one cycle, since the bubble clears ex_memread_i.
REQ-026 Jump response: ifid_flush_o=1, all enables 1.
REQ-027 A jump coinciding with load_use SHALL NOT flush; the jump stays in ID and is flushed the following cycle.
REQ-028 FSM transition RUN->MEM_WAIT when mem_stall=1; mem_req_i & mem_ack_i together is a zero-wait access and the FSM stays in RUN.
REQ-029 FSM transition MEM_WAIT->RUN on the first cycle with mem_ack_i=1.
REQ-030 FSM transition MEM_WAIT->HALT when the wait counter reaches MEM_TIMEOUT with mem_ack_i=0.
REQ-031 The wait counter SHALL count mem_stall cycles, be cleared in RUN, and therefore equal 1 on entry to MEM_WAIT.
REQ-032 HALT SHALL be absorbing until reset: all enables 0, all flushes 0, memwb_bubble_o=1, halt_o=1.
REQ-033 stall_cnt_o SHALL increment once per cycle with mem_stall, or with load_use not overridden by a branch.
REQ-034 flush_cnt_o SHALL increment once per cycle with ifid_flush_o=1.
REQ-035 Both counters SHALL saturate at all-ones and never wrap.
REQ-036 Outputs SHALL be combinational from current state and inputs; only state, the wait counter and the event counters are registered.

Reset
REQ-037 On rising clk_i with rst_i=1, SHALL set state=RUN, wait counter=0, stall_cnt_o=0, flush_cnt_o=0 and halt_o=0.
REQ-038 Reset SHALL override any concurrent transition or count, including exit from HALT and reset mid-MEM_WAIT.

Structure
REQ-039 State encodings and default parameter values SHALL live in the shared package pipe_ctrl_pkg.
REQ-040 A single sub-module sat_counter (parameterized width, inc, clear) SHALL be instantiated for both event counters.

Verification
REQ-041 SHALL test load-use: ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 -> one cycle with pc_write_o=0, ifid_write_o=0, idex_flush_o=1; stall_cnt_o=1.
REQ-042 SHALL test branch override: ex_branch_taken_i=1 with a concurrent load_use -> ifid_flush_o=1, idex_flush_o=1, pc_write_o=1; stall_cnt_o unchanged, flush_cnt_o+1.
REQ-043 SHALL test memory wait: mem_req_i=1 with mem_ack_i=0 for 3 cycles, then ack -> state_o 1,1,1 then 0; enables 0 for 3 cycles; stall_cnt_o=3.
REQ-044 SHALL test timeout: mem_ack_i held 0 for 15 cycles -> state_o=2, halt_o=1, all enables 0; stays HALT until rst_i=1, then RUN with counters 0.
REQ-045 SHALL test r0 and jump deferral: ex_rd_i=0 matching -> no stall; a jump concurrent with load_use -> ifid_flush_o only on the next cycle.
REQ-046 SHALL test saturation: CNT_W=4 with 20 load-use events -> stall_cnt_o=15.
